// File: rtl/time_keeper_display_if.sv
// time_keeper_display_if: divider ticks and buttons in, display and BCD time out
interface time_keeper_display_if;
   logic       secondClock;
   logic       displayClock;
   logic       setHour;
   logic       setMinute;
   logic [3:0] anode;
   logic [6:0] cathode;
   logic       dp;
   logic [7:0] hourBCD;
   logic [7:0] minuteBCD;
   logic [7:0] secondBCD;
   modport master (
      output secondClock, displayClock, setHour, setMinute,
      input  anode, cathode, dp, hourBCD, minuteBCD, secondBCD
   );
   modport slave (
      input  secondClock, displayClock, setHour, setMinute,
      output anode, cathode, dp, hourBCD, minuteBCD, secondBCD
   );
endinterface

// File: rtl/time_keeper_display.sv
// time_keeper_display: BCD wall clock with a multiplexed HH.MM seven-segment scan
module time_keeper_display #(
   parameter bit USE_12H  = 1'b0,
   parameter bit DP_BLINK = 1'b1
) (
   input logic                  cmosClock,
   input logic                  resetN,
   time_keeper_display_if.slave bus
);
   localparam logic [7:0] HOUR_MAX = USE_12H ? 8'h12 : 8'h23;
   localparam logic [7:0] HOUR_LOW = USE_12H ? 8'h01 : 8'h00;
   localparam logic [7:0] HOUR_RST = USE_12H ? 8'h12 : 8'h00;
   logic [3:0] s1, s2, hist, ev;
   logic [1:0] idx;
   logic       sec_tick, min_carry, hour_inc;
   logic [3:0] digit;
   logic [6:0] seg;

   function automatic logic [7:0] bcd_inc(input logic [7:0] v, input logic [7:0] top, input logic [7:0] low);
      return (v == top) ? low : (v[3:0] == 4'd9) ? {v[7:4] + 4'd1, 4'd0} : {v[7:4], v[3:0] + 4'd1};
   endfunction

   // bit order {setMinute, setHour, displayClock, secondClock}; ev is one pulse per rising edge
   always_ff @(posedge cmosClock or negedge resetN)
      if (!resetN) begin
         s1   <= '0;
         s2   <= '0;
         hist <= '0;
      end else begin
         s1   <= {bus.setMinute, bus.setHour, bus.displayClock, bus.secondClock};
         s2   <= s1;
         hist <= s2;
      end

   assign ev        = s2 & ~hist;
   assign sec_tick  = ev[0] & ~ev[3];
   assign min_carry = sec_tick && bus.secondBCD == 8'h59;
   assign hour_inc  = ev[2] | (min_carry && bus.minuteBCD == 8'h59);

   // time counters and scan index; a minute set clears seconds and swallows a same-cycle tick
   always_ff @(posedge cmosClock or negedge resetN)
      if (!resetN) begin
         bus.hourBCD   <= HOUR_RST;
         bus.minuteBCD <= 8'h00;
         bus.secondBCD <= 8'h00;
         idx           <= 2'd0;
      end else begin
         bus.secondBCD <= ev[3] ? 8'h00 : sec_tick ? bcd_inc(bus.secondBCD, 8'h59, 8'h00) : bus.secondBCD;
         bus.minuteBCD <= (ev[3] | min_carry) ? bcd_inc(bus.minuteBCD, 8'h59, 8'h00) : bus.minuteBCD;
         bus.hourBCD   <= hour_inc ? bcd_inc(bus.hourBCD, HOUR_MAX, HOUR_LOW) : bus.hourBCD;
         idx           <= idx + {1'b0, ev[1]};
      end

   // select the digit under the scan index and encode it, blanking a leading hour zero in 12h mode
   always_comb begin
      seg   = 7'h7f;
      digit = idx == 2'd0 ? bus.minuteBCD[3:0] : idx == 2'd1 ? bus.minuteBCD[7:4] :
              idx == 2'd2 ? bus.hourBCD[3:0] : bus.hourBCD[7:4];
      case (digit)
         4'd0: seg = 7'h40;
         4'd1: seg = 7'h79;
         4'd2: seg = 7'h24;
         4'd3: seg = 7'h30;
         4'd4: seg = 7'h19;
         4'd5: seg = 7'h12;
         4'd6: seg = 7'h02;
         4'd7: seg = 7'h78;
         4'd8: seg = 7'h00;
         4'd9: seg = 7'h10;
         default: seg = 7'h7f;
      endcase
      if (USE_12H && idx == 2'd3 && digit == 4'd0) seg = 7'h7f;
   end

   // registered display drive; the colon dp sits on digit 2
   always_ff @(posedge cmosClock or negedge resetN)
      if (!resetN) begin
         bus.anode   <= 4'b1110;
         bus.cathode <= 7'h40;
         bus.dp      <= 1'b1;
      end else begin
         bus.anode   <= ~(4'b0001 << idx);
         bus.cathode <= seg;
         bus.dp      <= (idx == 2'd2) ? (DP_BLINK ? ~s2[0] : 1'b0) : 1'b1;
      end
endmodule

// File: tb/tb_time_keeper_display.sv
// tb_time_keeper_display: 24h/blinking and 12h/steady instances against a time-of-day model
module tb_time_keeper_display;
   localparam int N = 16384;
   typedef struct packed {
      logic [23:0] bcd_a;
      logic [23:0] bcd_b;
      logic [11:0] disp_a;
      logic [11:0] disp_b;
   } exp_t;

   logic cmosClock = 1'b0;
   logic resetN = 1'b0;
   logic sc = 1'b0, dc = 1'b0, shb = 1'b0, smb = 1'b0;

   time_keeper_display_if bus_a ();
   time_keeper_display_if bus_b ();
   assign bus_a.secondClock = sc;
   assign bus_a.displayClock = dc;
   assign bus_a.setHour = shb;
   assign bus_a.setMinute = smb;
   assign bus_b.secondClock = sc;
   assign bus_b.displayClock = dc;
   assign bus_b.setHour = shb;
   assign bus_b.setMinute = smb;

   time_keeper_display #(.USE_12H(1'b0), .DP_BLINK(1'b1)) dut_a (.cmosClock(cmosClock), .resetN(resetN), .bus(bus_a));
   time_keeper_display #(.USE_12H(1'b1), .DP_BLINK(1'b0)) dut_b (.cmosClock(cmosClock), .resetN(resetN), .bus(bus_b));

   always #5 cmosClock = ~cmosClock;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
   bit lv_sec [N], lv_dsp [N], lv_sh [N], lv_sm [N], rz [N];
   bit e_sec [N], e_dsp [N], e_sh [N], e_sm [N];
   int cyc = 4, h24 = 0, h12 = 12, mm = 0, ss = 0, idx = 0;
   int chk_cnt = 0, pass_cnt = 0;
   bit s_l = 1'b0;
   exp_t q [$];

   function automatic logic [7:0] bcd(input int v);
      return 8'((v / 10) * 16 + v % 10);
   endfunction

   // what the display shows for the current model time and scan position
   function automatic logic [11:0] disp(input int h, input bit m12, input bit blink, input bit sync);
      int d;
      logic [6:0] c;
      logic [3:0] an;
      d  = idx == 0 ? mm % 10 : idx == 1 ? mm / 10 : idx == 2 ? h % 10 : h / 10;
      c  = (m12 && idx == 3 && h < 10) ? 7'h7f : seg_tab[d];
      an = ~(4'b0001 << idx);
      return {an, c, idx == 2 ? (blink ? ~sync : 1'b0) : 1'b1};
   endfunction

   // time-of-day rules for events landing this cycle
   task automatic apply(input int n);
      bit carry;
      carry = 1'b0;
      if (e_sm[n]) begin
         mm = (mm + 1) % 60;
         ss = 0;
      end else if (e_sec[n]) begin
         ss++;
         if (ss == 60) begin
            ss = 0;
            mm++;
            if (mm == 60) begin
               mm = 0;
               carry = 1'b1;
            end
         end
      end
      if (e_sh[n] || carry) begin
         h24 = (h24 + 1) % 24;
         h12 = h12 == 12 ? 1 : h12 + 1;
      end
      if (e_dsp[n]) idx = (idx + 1) % 4;
   endtask

   // drive one cycle of inputs and push what both DUTs must show at this cycle's falling edge
   task automatic step(input bit rn, input bit s, input bit d, input bit h, input bit m);
      int n;
      bit sy;
      exp_t e;
      @(posedge cmosClock);
      #2;
      cyc++;
      n = cyc;
      if (n >= N - 8) begin
         $display("FAIL cycle_budget exceeded at %0d, limit %0d", n, N - 8);
         $fatal(1);
      end
      if (rn && rz[n - 1]) begin
         s = 1'b0; d = 1'b0; h = 1'b0; m = 1'b0;
      end
      resetN = rn; sc = s; dc = d; shb = h; smb = m;
      lv_sec[n] = s; lv_dsp[n] = d; lv_sh[n] = h; lv_sm[n] = m; rz[n] = !rn;
      sy = (rz[n - 2] || rz[n - 3]) ? 1'b0 : lv_sec[n - 3];
      if (!rn) begin
         h24 = 0; h12 = 12; mm = 0; ss = 0; idx = 0;
         for (int k = n; k < n + 4; k++) begin
            e_sec[k] = 0; e_dsp[k] = 0; e_sh[k] = 0; e_sm[k] = 0;
         end
         e.disp_a = disp(h24, 1'b0, 1'b1, 1'b0);
         e.disp_b = disp(h12, 1'b1, 1'b0, 1'b0);
      end else begin
         e.disp_a = disp(h24, 1'b0, 1'b1, sy);
         e.disp_b = disp(h12, 1'b1, 1'b0, sy);
         apply(n);
         if (s && !lv_sec[n - 1]) e_sec[n + 3] = 1'b1;
         if (d && !lv_dsp[n - 1]) e_dsp[n + 3] = 1'b1;
         if (h && !lv_sh[n - 1]) e_sh[n + 3] = 1'b1;
         if (m && !lv_sm[n - 1]) e_sm[n + 3] = 1'b1;
      end
      e.bcd_a = {bcd(h24), bcd(mm), bcd(ss)};
      e.bcd_b = {bcd(h12), bcd(mm), bcd(ss)};
      q.push_back(e);
   endtask

   function automatic bit rnd();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic idle(input int n);
      repeat (n) step(1'b1, 1'b0, rnd(), 1'b0, 1'b0);
   endtask

   task automatic tick();
      step(1'b1, 1'b1, rnd(), 1'b0, 1'b0);
      step(1'b1, 1'b0, rnd(), 1'b0, 1'b0);
      idle(3);
   endtask

   task automatic press_h();
      step(1'b1, 1'b0, rnd(), 1'b1, 1'b0);
      step(1'b1, 1'b0, rnd(), 1'b0, 1'b0);
      idle(3);
   endtask

   task automatic press_m();
      step(1'b1, 1'b0, rnd(), 1'b0, 1'b1);
      step(1'b1, 1'b0, rnd(), 1'b0, 1'b0);
      idle(3);
   endtask

   // reach a target time with button presses (a minute press also clears seconds) and ticks
   task automatic set_time(input int h, input int m, input int s, input bit use12);
      while ((use12 ? h12 : h24) != h) press_h();
      press_m();
      while (mm != m) press_m();
      while (ss != s) tick();
   endtask

   task automatic check(input string nm, input logic [23:0] act, input logic [23:0] exp);
      chk_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s at cycle %0d: got %h, expected %h", nm, cyc, act, exp);
   endtask

   // monitor: every falling edge the DUTs present outputs; pop the matching expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge cmosClock);
         if (q.size() > 0) begin
            e = q.pop_front();
            check("bcd_24h", {bus_a.hourBCD, bus_a.minuteBCD, bus_a.secondBCD}, e.bcd_a);
            check("bcd_12h", {bus_b.hourBCD, bus_b.minuteBCD, bus_b.secondBCD}, e.bcd_b);
            check("disp_24h_blink", {12'h0, bus_a.anode, bus_a.cathode, bus_a.dp}, {12'h0, e.disp_a});
            check("disp_12h_steady", {12'h0, bus_b.anode, bus_b.cathode, bus_b.dp}, {12'h0, e.disp_b});
         end
      end
   end

   initial begin
      for (int k = 0; k <= 4; k++) rz[k] = 1'b1;
      for (int k = 0; k < 8; k++) step(1'b0, 1'(k % 2), 1'(~k % 2), 1'b0, 1'b0);
      step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
      idle(4);
      tick();
      set_time(23, 59, 58, 1'b0);
      tick();
      tick();
      set_time(12, 59, 59, 1'b1);
      tick();
      set_time(9, 30, 0, 1'b1);
      idle(40);
      set_time(10, 20, 59, 1'b0);
      step(1'b1, 1'b1, rnd(), 1'b0, 1'b1);
      step(1'b1, 1'b0, rnd(), 1'b0, 1'b0);
      idle(3);
      set_time(10, 59, 59, 1'b0);
      step(1'b1, 1'b1, rnd(), 1'b1, 1'b0);
      step(1'b1, 1'b0, rnd(), 1'b0, 1'b0);
      idle(3);
      set_time(13, 45, 0, 1'b0);
      idle(30);
      while (ss != 37) tick();
      for (int k = 0; k < 200 && idx != 2; k++) step(1'b1, 1'b0, rnd(), 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
      idle(20);
      for (int k = 0; k < 3000; k++) begin
         if ($urandom_range(0, 2) == 0) s_l = ~s_l;
         step($urandom_range(0, 599) != 0, s_l, rnd(), $urandom_range(0, 39) == 0, $urandom_range(0, 29) == 0);
      end
      idle(6);
      repeat (2) @(negedge cmosClock);
      chk_cnt++;
      if (q.size() == 0) pass_cnt++;
      else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule
